// File: rtl/rgb2yuv_mac_sched_if.sv
// rgb2yuv_mac_sched_if
//   Pixel-side bus of the time-multiplexed RGB->YUV converter.
//   Upstream drives dvi/dtypei/r/g/b/meta_datai and watches rdyo.
//   The converter drives dvo/dtypeo/y/u/v/meta_datao.
//   Modports:
//     master : the pixel source/sink side (e.g. upstream pipeline stage)
//     slave  : the converter itself
//   DTYPE_WIDTH falls back to 4 when the build does not define it.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

interface rgb2yuv_mac_sched_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic                    dvi;
  logic                    rdyo;
  logic [`DTYPE_WIDTH-1:0] dtypei;
  logic [PIXEL_WIDTH-1:0]  r;
  logic [PIXEL_WIDTH-1:0]  g;
  logic [PIXEL_WIDTH-1:0]  b;
  logic [15:0]             meta_datai;
  logic                    dvo;
  logic [`DTYPE_WIDTH-1:0] dtypeo;
  logic [PIXEL_WIDTH-1:0]  y;
  logic [PIXEL_WIDTH-1:0]  u;
  logic [PIXEL_WIDTH-1:0]  v;
  logic [15:0]             meta_datao;

  modport master (
    output dvi, dtypei, r, g, b, meta_datai,
    input  rdyo, dvo, dtypeo, y, u, v, meta_datao
  );

  modport slave (
    input  dvi, dtypei, r, g, b, meta_datai,
    output rdyo, dvo, dtypeo, y, u, v, meta_datao
  );
endinterface

// File: rtl/rgb2yuv_mac_sched.sv
// rgb2yuv_mac_sched
//   Time-multiplexed RGB->YUV converter. A single signed 9b x PIXEL_WIDTH
//   multiply-accumulate unit is stepped 9 times per pixel (Y, U, V rows of a
//   3x3 matrix, coefficient value/256). Y is unsigned full range, U/V are
//   signed two's complement without offset. The coefficient matrix has a
//   shadow bank (written any time) and an active bank (updated on frame sync,
//   deferred to the end of the current pixel while one is in flight).
//   Ports:
//     clk, reset     : clock, synchronous active-high reset
//     enable         : 1 = convert, 0 = pass r/g/b through (captured at accept)
//     coef_wr/addr/data : shadow bank write (addr 0..8, 9..15 ignored)
//     frame_sync     : copy shadow bank into active bank
//     pix            : pixel bus (dvi/rdyo in, dvo/y/u/v out), slave modport
//     clamp_cnt      : count of converted pixels that clamped (optional)
//   Optional feature macro: RGB2YUV_MAC_SCHED_CLAMP_CNT_EN adds clamp_cnt.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module rgb2yuv_mac_sched #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              coef_wr,
  input  logic [3:0]        coef_addr,
  input  logic signed [8:0] coef_data,
  input  logic              frame_sync,
`ifdef RGB2YUV_MAC_SCHED_CLAMP_CNT_EN
  output logic [15:0]       clamp_cnt,
`endif
  rgb2yuv_mac_sched_if.slave pix
);
  localparam int PW     = PIXEL_WIDTH;
  localparam int PROD_W = PW + 10;
  localparam int ACC_W  = PW + 11;
  localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(128);
  localparam logic signed [ACC_W-1:0] Y_MAX   = ACC_W'((1 << PW) - 1);
  localparam logic signed [ACC_W-1:0] S_MAX   = ACC_W'((1 << (PW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN   = ACC_W'(-(1 << (PW - 1)));
  localparam logic signed [8:0] DEF_COEF [9] = '{
    9'sd66, 9'sd129, 9'sd25, -9'sd38, -9'sd74, 9'sd112, 9'sd112, -9'sd94, -9'sd18
  };

  typedef enum logic {IDLE, MAC} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              step_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [PW-1:0]           r_q, g_q, b_q;
  logic                    en_q;
  logic [`DTYPE_WIDTH-1:0] dtype_q, dtypeo_q;
  logic [15:0]             meta_q, metao_q;
  logic [PW-1:0]           y_hold, u_hold, y_q, u_q, v_q;
  logic                    dvo_q;
  logic                    sync_pending;
  logic signed [8:0]       coef_shadow [9];
  logic signed [8:0]       coef_active [9];
  logic signed [8:0]       shadow_fwd  [9];

  logic                     accept, in_mac, last_step, chan_end;
  logic                     wr_hit, copy_now, set_pending;
  logic [PW-1:0]            pix_sel;
  logic signed [8:0]        coef_sel;
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  acc_sum, rounded;
  logic [PW-1:0]            ch_val;

  assign pix.rdyo       = (state_q == IDLE);
  assign pix.dvo        = dvo_q;
  assign pix.y          = y_q;
  assign pix.u          = u_q;
  assign pix.v          = v_q;
  assign pix.dtypeo     = dtypeo_q;
  assign pix.meta_datao = metao_q;

  always_comb begin
    accept    = (state_q == IDLE) && pix.dvi;
    in_mac    = (state_q == MAC);
    last_step = in_mac && (step_q == 4'd8);
    chan_end  = in_mac && ((step_q == 4'd2) || (step_q == 4'd5) || (step_q == 4'd8));
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pix.dvi) state_d = MAC;
      MAC:     if (step_q == 4'd8) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Step k multiplies coefficient k by R, G or B (k mod 3); the pixel is
  // zero-extended so the product is always a signed value.
  always_comb begin
    case (step_q)
      4'd0, 4'd3, 4'd6: pix_sel = r_q;
      4'd1, 4'd4, 4'd7: pix_sel = g_q;
      default:          pix_sel = b_q;
    endcase
    coef_sel = (step_q <= 4'd8) ? coef_active[step_q] : 9'sd0;
    product  = PROD_W'(coef_sel) * PROD_W'($signed({1'b0, pix_sel}));
    acc_sum  = acc_q + ACC_W'(product);
    rounded  = (acc_sum + ROUND_K) >>> 8;
  end

  // Step 2 finishes Y (unsigned range); steps 5 and 8 finish U/V (signed range).
  always_comb begin
    ch_val = rounded[PW-1:0];
    if (step_q == 4'd2) begin
      if (rounded[ACC_W-1])      ch_val = '0;
      else if (rounded > Y_MAX)  ch_val = '1;
    end else begin
      if (rounded < S_MIN)       ch_val = S_MIN[PW-1:0];
      else if (rounded > S_MAX)  ch_val = S_MAX[PW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= '0;
      acc_q    <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      en_q     <= 1'b0;
      dtype_q  <= '0;
      meta_q   <= '0;
      y_hold   <= '0;
      u_hold   <= '0;
      y_q      <= '0;
      u_q      <= '0;
      v_q      <= '0;
      dtypeo_q <= '0;
      metao_q  <= '0;
      dvo_q    <= 1'b0;
    end else begin
      dvo_q <= 1'b0;
      if (accept) begin
        r_q     <= pix.r;
        g_q     <= pix.g;
        b_q     <= pix.b;
        en_q    <= enable;
        dtype_q <= pix.dtypei;
        meta_q  <= pix.meta_datai;
        acc_q   <= '0;
        step_q  <= '0;
      end else if (in_mac) begin
        step_q <= last_step ? 4'd0 : step_q + 4'd1;
        acc_q  <= chan_end ? '0 : acc_sum;
        if (step_q == 4'd2) y_hold <= ch_val;
        if (step_q == 4'd5) u_hold <= ch_val;
        if (last_step) begin
          dvo_q    <= 1'b1;
          y_q      <= en_q ? y_hold : r_q;
          u_q      <= en_q ? u_hold : g_q;
          v_q      <= en_q ? ch_val : b_q;
          dtypeo_q <= dtype_q;
          metao_q  <= meta_q;
        end
      end
    end
  end

  // A write landing on the same edge as a copy is forwarded so the active
  // bank sees the new value. A sync that arrives while a pixel is in flight
  // (or with its accept) is held and applied as the pixel completes.
  always_comb begin
    wr_hit     = coef_wr && (coef_addr <= 4'd8);
    shadow_fwd = coef_shadow;
    if (wr_hit) shadow_fwd[coef_addr] = coef_data;
    copy_now    = ((state_q == IDLE) && frame_sync && !pix.dvi) ||
                  (last_step && (sync_pending || frame_sync));
    set_pending = frame_sync && (accept || (in_mac && !last_step));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coef_shadow  <= DEF_COEF;
      coef_active  <= DEF_COEF;
      sync_pending <= 1'b0;
    end else begin
      if (wr_hit) coef_shadow[coef_addr] <= coef_data;
      if (copy_now) begin
        coef_active  <= shadow_fwd;
        sync_pending <= 1'b0;
      end else if (set_pending) begin
        sync_pending <= 1'b1;
      end
    end
  end

`ifdef RGB2YUV_MAC_SCHED_CLAMP_CNT_EN
  logic ch_clamped, clamp_seen, clamp_inc;

  always_comb begin
    if (step_q == 4'd2) ch_clamped = rounded[ACC_W-1] || (rounded > Y_MAX);
    else                ch_clamped = (rounded < S_MIN) || (rounded > S_MAX);
    clamp_inc = last_step && en_q && (clamp_seen || ch_clamped);
  end

  // A bank copy restarts the count; a clamped pixel finishing on that same
  // edge is the first one counted against the new matrix.
  always_ff @(posedge clk) begin
    if (reset) begin
      clamp_seen <= 1'b0;
      clamp_cnt  <= '0;
    end else begin
      if (accept)                     clamp_seen <= 1'b0;
      else if (chan_end && ch_clamped) clamp_seen <= 1'b1;
      if (copy_now)
        clamp_cnt <= clamp_inc ? 16'd1 : 16'd0;
      else if (clamp_inc && (clamp_cnt != 16'hFFFF))
        clamp_cnt <= clamp_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/rgb2yuv_mac_sched.md
Name: rgb2yuv_mac_sched

Overview:
- Time-multiplexed RGB->YUV converter. One signed 9b x PIXEL_WIDTH multiply-accumulate unit is sequenced over 9 steps per pixel.
- Holds a programmable 3x3 colour matrix with shadow/active banks. The active bank updates only on frame sync.
- Sits in the imager pipeline where throughput per pixel is low, trading DSP area for cycles. Upstream handshake is dvi/rdyo.
- Output format: Y unsigned full-range; U and V signed two's complement with no offset.

Parameters:
- PIXEL_WIDTH, 8, width of each r/g/b input and y/u/v output.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = convert; 0 = pass r/g/b through unchanged on y/u/v. Sampled at accept.
- coef_wr  in  1  write strobe into the shadow coefficient bank.
- coef_addr  in  4  0..8 = Y_R,Y_G,Y_B,U_R,U_G,U_B,V_R,V_G,V_B; 9..15 ignored.
- coef_data  in  9  signed coefficient, value/256.
- frame_sync  in  1  request to copy shadow bank to active bank.
- dvi  in  1  input pixel valid.
- rdyo  out  1  block can accept a pixel.
- dtypei  in  `DTYPE_WIDTH  data type, passed through.
- r, g, b  in  PIXEL_WIDTH each  unsigned pixel.
- meta_datai  in  16  passed through.
- dvo  out  1  one-cycle output valid.
- dtypeo  out  `DTYPE_WIDTH  captured dtypei.
- y, u, v  out  PIXEL_WIDTH each  result.
- meta_datao  out  16  captured meta_datai.

Behaviour:
- Reset:
  - dvo=0, rdyo=1, dtypeo/meta_datao/y/u/v=0.
  - State IDLE, step counter 0, sync_pending=0.
  - Both coefficient banks loaded with 66,129,25,-38,-74,112,112,-94,-18.
  - Reset mid-pixel aborts the pixel; no dvo is produced for it.
- States:
  - IDLE: rdyo=1. On dvi=1, capture r/g/b/dtypei/meta_datai/enable, clear accumulator, go to MAC.
  - MAC: rdyo=0. Steps 0..8, one product per clock: step k uses coefficient k times pixel (R,G,B)[k mod 3].
    - Channel Y is steps 0-2, U is 3-5, V is 6-8.
    - At the end of steps 2, 5 and 8, round and clamp the channel sum into a holding register, then clear the accumulator.
    - After step 8, load y/u/v, pulse dvo for one cycle, return to IDLE.
- Timing:
  - Accept edge E0; dvo is high in the cycle after edge E9.
  - rdyo returns high in that same cycle, so a new pixel can be accepted on the edge that ends the dvo cycle.
  - Maximum throughput is 1 pixel per 10 cycles.
  - dvi while rdyo=0 is ignored. Upstream must hold the pixel until accepted.
- Arithmetic:
  - Product is signed PIXEL_WIDTH+10 bits, with the pixel zero-extended.
  - Accumulator is signed PIXEL_WIDTH+11 bits.
  - Per channel: sum + 128, then arithmetic shift right by 8.
  - Y clamps to [0, 2^PW-1].
  - U and V clamp to [-2^(PW-1), 2^(PW-1)-1] and are output as two's complement.
- Bypass: if enable=0 was captured, timing is unchanged and y/u/v=r/g/b.
- dtypeo and meta_datao update together with dvo and hold until the next result.
- Coefficient banks:
  - coef_wr with addr<=8 writes the shadow bank every cycle, regardless of state.
  - frame_sync in IDLE with no accept that cycle: active<=shadow on that edge.
  - Write and copy on the same edge: active receives the newly written value (forwarded).
  - frame_sync while in MAC, or coincident with an accept: set sync_pending. The copy happens on the edge that returns to IDLE, so the current pixel uses the old matrix throughout.
  - A forwarded write applies on a pending copy as well.
  - Multiple syncs while pending collapse into one copy.

Optional Feature:
- Macro: RGB2YUV_MAC_SCHED_CLAMP_CNT_EN.
- Defined:
  - Adds output clamp_cnt [15:0], reset to 0.
  - Increments by 1 per output pixel in which any of Y/U/V clamped, only when conversion is enabled.
  - Saturates at 0xFFFF.
  - Cleared to 0 on an applied active-bank copy. If an increment coincides with the clear, the result is 1.
- Undefined: port absent; no counter logic.

Test Plan:
- PW=8, default coefficients, r=g=b=255, enable=1 -> y=219 (0xDB), u=0x00, v=0x00; dvo exactly 10 cycles after the accept edge, 1 cycle wide.
- r=255, g=0, b=0 -> y=66 (0x42), u=-38 (0xDA), v=112 (0x70); dtypeo/meta_datao equal the captured inputs.
- Write Y_R=Y_G=Y_B=255 and U_R=U_G=U_B=-256, then frame_sync; r=g=b=255 -> y=0xFF (clamped), u=0x80 (clamped), v=0x00; clamp_cnt=1 if the macro is enabled.
- dvi held high with a new pixel each accept -> rdyo low for 9 cycles after each accept; one dvo every 10 cycles; no pixel lost or duplicated.
- Write Y_R=0 during the MAC of pixel A and pulse frame_sync mid-pixel; A and B both red 255 -> A y=66; B (accepted after) y=0.
- Assert reset at step 4 -> no dvo; rdyo=1 next cycle; coefficients restored to defaults (red pixel again gives y=66). enable=0 with r,g,b=12,34,56 -> y,u,v=12,34,56 at the same latency.
